// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU select codes, opcode fields and sequencer state encoding
package alu_ctrl_pkg;
    localparam logic [2:0] SEL_AND  = 3'b000;
    localparam logic [2:0] SEL_OR   = 3'b001;
    localparam logic [2:0] SEL_ADD  = 3'b010;
    localparam logic [2:0] SEL_SUB  = 3'b011;
    localparam logic [2:0] SEL_SLT  = 3'b100;
    localparam logic [2:0] SEL_ADD5 = 3'b101;
    localparam logic [2:0] SEL_SUB6 = 3'b110;
    localparam logic [2:0] SEL_ADD7 = 3'b111;
    localparam int OP_MUL_BIT = 3;
    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_RESP} state_t;
endpackage

// File: rtl/settle_timer.sv
// settle_timer: loadable 4-bit down-counter that flags when it has run out
module settle_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       done
);
    logic [3:0] cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != 0) cnt <= cnt - 4'd1;
    assign done = cnt == 0;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives the ALU for single ops and a 32-step shift-add multiply
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [2:0]  alu_sel,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic        rsp_zero,
    output logic        busy
);
    state_t state, state_nx;
    logic load, done;
    logic [31:0] mc, mp;
    logic [4:0] step, step_nx;
    settle_timer u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .load_val(4'(SETTLE_CYCLES - 1)),
        .done(done)
    );
    assign req_ready = state == ST_IDLE;
    assign busy      = state != ST_IDLE;
    assign rsp_valid = state == ST_RESP;
    assign rsp_zero  = rsp_result == 0;
    assign step_nx   = step + 5'd1;
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        case (state)
            ST_IDLE: if (req_valid) begin
                state_nx = req_op[OP_MUL_BIT] ? ST_MUL : ST_EXEC;
                load     = 1'b1;
            end
            ST_EXEC: state_nx = done ? ST_RESP : ST_EXEC;
            ST_MUL: if (done) begin
                state_nx = (step == 5'd31) ? ST_RESP : ST_MUL;
                load     = step != 5'd31;
            end
            ST_RESP: state_nx = rsp_ready ? ST_IDLE : ST_RESP;
            default: state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= ST_IDLE;
        else state <= state_nx;
    // mc/mp stay fixed; the step index selects the multiplier bit and shift, and alu_a carries the accumulator
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_sel    <= SEL_AND;
            alu_a      <= '0;
            alu_b      <= '0;
            mc         <= '0;
            mp         <= '0;
            step       <= '0;
            rsp_result <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    if (req_op[OP_MUL_BIT]) begin
                        mc      <= req_a;
                        mp      <= req_b;
                        step    <= '0;
                        alu_sel <= SEL_ADD;
                        alu_a   <= '0;
                        alu_b   <= req_b[0] ? req_a : '0;
                    end else begin
                        alu_sel <= req_op[2:0];
                        alu_a   <= req_a;
                        alu_b   <= req_b;
                    end
                end
                ST_EXEC: if (done) rsp_result <= alu_result;
                ST_MUL: if (done) begin
                    if (step == 5'd31) rsp_result <= alu_result;
                    else begin
                        step  <= step_nx;
                        alu_a <= alu_result;
                        alu_b <= mp[step_nx] ? (mc << step_nx) : '0;
                    end
                end
                default: ;
            endcase
        end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sits between the control unit and the 32-bit ALU result multiplexer. It accepts one operation at a time over a valid/ready handshake and drives the ALU select and operand buses. It waits a fixed settle time and then captures the result. It also sequences an iterative 32-step shift-add multiply on the ALU adder path. Results leave through a valid/ready response port with a zero flag.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each ALU evaluation is held before capture; legal range 1..15.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_op` in 4: bit 3 set means MUL (bits 2:0 ignored); otherwise bits 2:0 are the ALU select code.
- `req_a`, `req_b` in 32: operands (for MUL: multiplicand, multiplier).
- `alu_sel` out 3: to ALU mux select.
- `alu_a`, `alu_b` out 32: to ALU operand inputs.
- `alu_result` in 32: ALU mux output.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer takes result.
- `rsp_result` out 32: captured result.
- `rsp_zero` out 1: `rsp_result == 0`.
- `busy` out 1: state is not IDLE.

## Operation
- ALU select codes: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 ADD, 110 SUB, 111 ADD. The controller passes codes through unchanged and never reinterprets them.
- States: IDLE, EXEC, MUL_STEP, RESP.
- **IDLE:** `req_ready` is 1.
  - On `req_valid & req_ready` with `req_op[3]=0`: latch `alu_sel=req_op[2:0]`, `alu_a=req_a`, `alu_b=req_b`, load `cnt=SETTLE_CYCLES-1`, and go to EXEC.
  - With `req_op[3]=1`: latch multiplicand `mc=req_a` and multiplier `mp=req_b`, set `acc=0`, `step=0`, `alu_sel=010`, `alu_a=0`, `alu_b=(req_b[0] ? req_a : 0)`, load `cnt`, and go to MUL_STEP.
- **EXEC:** while `cnt!=0`, decrement `cnt`. When `cnt==0`, capture `rsp_result=alu_result` and go to RESP.
- **MUL_STEP:** while `cnt!=0`, decrement `cnt`. When `cnt==0`:
  - `acc=alu_result`.
  - If `step==31`: `rsp_result=alu_result` and go to RESP.
  - Otherwise: `step++`, `mc=mc<<1`, `mp=mp>>1`, `alu_a=alu_result`, `alu_b=(mp_next[0] ? mc_next : 0)`, reload `cnt`.
  - Here `mp_next` and `mc_next` are the shifted values just computed.
- Multiply result is the low 32 bits of the product (unsigned; two's-complement low word is identical). Shifted-out bits are discarded. No overflow flag.
- **RESP:** `rsp_valid=1`; `rsp_result` and `rsp_zero` are held stable. On `rsp_ready`, go to IDLE. `alu_*` outputs hold their last values.
- `req_ready` is 0 in RESP, so there is no back-to-back accept in the same cycle as response handoff.
- Requests presented while not in IDLE are not accepted; the requester must hold them.

## Timing
- Reset (async, immediate):
  - State IDLE, `alu_sel=000`, `alu_a=alu_b=0`.
  - `rsp_valid=0`, `rsp_result=0`, `rsp_zero=1`, `busy=0`.
  - Internal `acc`, `mc`, `mp`, `step`, `cnt` are 0.
  - `req_ready=1` (no accept occurs while `rst_n` is low).
- Non-MUL latency: accept at edge E0; `alu_*` valid after E0; capture at edge E(SETTLE_CYCLES); `rsp_valid` high from that edge. With default 2, there are 2 cycles from accept to `rsp_valid`.
- MUL latency: 32×SETTLE_CYCLES cycles from accept to `rsp_valid` (64 at default). The latency is fixed and independent of operand values.
- `rsp_ready` already high when `rsp_valid` rises: exactly one RESP cycle, then IDLE; the next accept is possible one cycle later.
- Reset asserted mid-EXEC, mid-MUL, or in RESP: the operation is abandoned and there is no response; all outputs take reset values.
- `rsp_zero` is combinational from the `rsp_result` register.

## Structure
- Shared package `alu_ctrl_pkg`:
  - ALU select localparams `SEL_AND`..`SEL_ADD7` (000..111).
  - `OP_MUL_BIT=3`.
  - State encoding.
- One sub-module, `settle_timer`: loadable down-counter, 4 bits wide, with `load`, `load_val` and `done` (`cnt==0`). It is instantiated once and shared by EXEC and MUL_STEP.

## Test plan
- AND: `req_op=0000`, `a=0xF0F0F0F0`, `b=0xFF00FF00`, ALU model returns `a&b` → after 2 cycles `rsp_result=0xF000F000`, `rsp_zero=0`, `alu_sel=000` during EXEC.
- SUB equal: `req_op=0011`, `a=b=0x12345678` → `rsp_result=0`, `rsp_zero=1`; SLT `op=0100`, `a=3`, `b=5` → result 1.
- MUL: `req_op=1xxx`, `a=7`, `b=6` → `rsp_valid` exactly 64 cycles after accept, result 42; `a=0xFFFFFFFF`, `b=2` → `0xFFFFFFFE` (wrap).
- Backpressure: hold `rsp_ready=0` for 10 cycles after `rsp_valid` → `rsp_result` stable, `req_ready=0`, a pending `req_valid` is not accepted until the cycle after `rsp_ready`.
- Reset mid-MUL: drop `rst_n` at step 10 → immediate reset values, no `rsp_valid`; a new ADD `1+2` after release → 3.
- `SETTLE_CYCLES=1`: ADD latency 1 cycle, MUL latency 32 cycles, `5*5=25`.
